// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver, the receive FIFO and the host drain logic.
// The slave modport is the FIFO side; master is the receiver/host side.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          rx_done;
  logic          rx_error;
  logic [7:0]    rx_out;
  logic [3:0]    length;
  logic          rd_en;
  logic          flush;
  logic          ovf_clr;
  logic [7:0]    rd_data;
  logic          rd_err;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  modport slave (
    input  rx_done, rx_error, rx_out, length, rd_en, flush, ovf_clr,
    output rd_data, rd_err, empty, full, count, overflow
  );

  modport master (
    output rx_done, rx_error, rx_out, length, rd_en, flush, ovf_clr,
    input  rd_data, rd_err, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: one masked byte per rx_done rising edge,
// show-ahead pop. Define UART_RXQ_ERR_TAG_EN to queue errored frames with an error tag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rstn,
  uart_rx_fifo_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef UART_RXQ_ERR_TAG_EN
  localparam int unsigned DW = 9;
`else
  localparam int unsigned DW = 8;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          rx_done_q;
  logic          empty_q;
  logic          full_q;
  logic          overflow_q;

  logic [7:0]    masked;
  logic [DW-1:0] wr_word;
  logic          push;
  logic          push_ok;
  logic          do_push;
  logic          do_pop;
  logic          drop;

  // Out-of-range lengths fall back to a full 8-bit byte.
  always_comb begin
    masked = bus.rx_out;
    case (bus.length)
      4'd5:    masked = bus.rx_out & 8'h1F;
      4'd6:    masked = bus.rx_out & 8'h3F;
      4'd7:    masked = bus.rx_out & 8'h7F;
      default: masked = bus.rx_out;
    endcase
  end

  // Full with a pop in the same cycle frees the slot the push needs; flush wins over both.
  always_comb begin
    push = bus.rx_done & ~rx_done_q;
`ifdef UART_RXQ_ERR_TAG_EN
    push_ok = push;
    wr_word = {bus.rx_error, masked};
`else
    push_ok = push & ~bus.rx_error;
    wr_word = masked;
`endif
    do_pop  = bus.rd_en & ~empty_q & ~bus.flush;
    do_push = push_ok & (~full_q | do_pop) & ~bus.flush;
    drop    = push_ok & full_q & ~bus.rd_en & ~bus.flush;

    count_d = count_q;
    if (bus.flush)
      count_d = '0;
    else if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (do_pop && !do_push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_done_q <= bus.rx_done;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CW'(DEPTH));
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop)
        overflow_q <= 1'b1;
      else if (bus.ovf_clr)
        overflow_q <= 1'b0;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_word;
  end

  assign bus.rd_data  = empty_q ? 8'h00 : mem[rd_ptr][7:0];
`ifdef UART_RXQ_ERR_TAG_EN
  assign bus.rd_err   = empty_q ? 1'b0 : mem[rd_ptr][8];
`else
  assign bus.rd_err   = 1'b0;
`endif
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [8:0] q[$];
  bit         m_ovf  = 0;
  bit         m_prev = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask_byte(input logic [7:0] b, input int len);
    if (len >= 5 && len <= 8) return 8'((int'(b)) % (1 << len));
    return b;
  endfunction

  task automatic check_all();
    check("count", 32'(bus.count), 32'(q.size()));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("full", 32'(bus.full), 32'(q.size() == DEPTH));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (q.size() > 0) begin
      check("rd_data", 32'(bus.rd_data), 32'(q[0][7:0]));
`ifdef UART_RXQ_ERR_TAG_EN
      check("rd_err", 32'(bus.rd_err), 32'(q[0][8]));
`else
      check("rd_err", 32'(bus.rd_err), 32'(0));
`endif
    end
  endtask

  // One clock: advance the model from the current inputs, then compare after the edge.
  task automatic step();
    bit rising, ok, set_ovf;
    rising  = bus.rx_done && !m_prev;
`ifdef UART_RXQ_ERR_TAG_EN
    ok = rising;
`else
    ok = rising && !bus.rx_error;
`endif
    set_ovf = 0;
    if (bus.flush) begin
      q.delete();
    end else begin
      if (bus.rd_en && q.size() > 0) void'(q.pop_front());
      if (ok) begin
        if (q.size() < DEPTH) q.push_back({bus.rx_error, mask_byte(bus.rx_out, int'(bus.length))});
        else set_ovf = 1;
      end
    end
    if (set_ovf) m_ovf = 1;
    else if (bus.ovf_clr) m_ovf = 0;
    m_prev = bus.rx_done;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    bus.rx_out   = b;
    bus.rx_error = err;
    bus.rx_done  = 1'b1;
    step();
    bus.rx_done  = 1'b0;
    bus.rx_error = 1'b0;
    step();
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'(0));
    check({tag, "_empty"}, 32'(bus.empty), 32'(1));
    check({tag, "_full"}, 32'(bus.full), 32'(0));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(0));
    check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(0));
    check({tag, "_rd_err"}, 32'(bus.rd_err), 32'(0));
  endtask

  initial begin
    logic [7:0] last_rd;
    bus.rx_done = 0; bus.rx_error = 0; bus.rx_out = 0; bus.length = 4'd8;
    bus.rd_en = 0; bus.flush = 0; bus.ovf_clr = 0;

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // T1: long rx_done pulse yields one entry
    bus.rx_out = 8'hA5; bus.rx_done = 1'b1;
    repeat (5) step();
    bus.rx_done = 1'b0;
    step();
    check("t1_count", 32'(bus.count), 32'(1));
    check("t1_data", 32'(bus.rd_data), 32'h A5);
    pop();

    // T2: masking
    bus.length = 4'd5;
    send(8'hFF, 1'b0);
    check("t2_len5", 32'(bus.rd_data), 32'h1F);
    pop();
    bus.length = 4'd0;
    send(8'hC3, 1'b0);
    check("t2_len0", 32'(bus.rd_data), 32'hC3);
    pop();
    bus.length = 4'd8;

    // T3: overfill then drain in order
    for (int i = 0; i < 17; i++) send(8'(i), 1'b0);
    check("t3_full", 32'(bus.full), 32'(1));
    check("t3_ovf", 32'(bus.overflow), 32'(1));
    for (int i = 0; i < 16; i++) begin
      check("t3_order", 32'(bus.rd_data), 32'(i));
      pop();
    end
    check("t3_empty", 32'(bus.empty), 32'(1));
    check("t3_ovf_sticky", 32'(bus.overflow), 32'(1));
    bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(bus.overflow), 32'(0));

    // T4: push+pop while full, then while empty
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
    bus.rd_en = 1'b1; bus.rx_done = 1'b1; bus.rx_out = 8'h77;
    step();
    bus.rd_en = 1'b0; bus.rx_done = 1'b0;
    step();
    check("t4_count_full", 32'(bus.count), 32'(16));
    check("t4_no_ovf", 32'(bus.overflow), 32'(0));
    last_rd = 8'h00;
    for (int i = 0; i < 16 && !bus.empty; i++) begin
      last_rd = bus.rd_data;
      pop();
    end
    check("t4_last", 32'(last_rd), 32'h77);
    bus.rd_en = 1'b1; bus.rx_done = 1'b1; bus.rx_out = 8'h12;
    step();
    bus.rd_en = 1'b0; bus.rx_done = 1'b0;
    step();
    check("t4_count_empty", 32'(bus.count), 32'(1));
    pop();

    // T5: errored frame
    send(8'h3C, 1'b1);
`ifdef UART_RXQ_ERR_TAG_EN
    check("t5_rd_err", 32'(bus.rd_err), 32'(1));
    check("t5_rd_data", 32'(bus.rd_data), 32'h3C);
    pop();
`else
    check("t5_empty", 32'(bus.empty), 32'(1));
`endif

    // T6: flush beats push
    for (int i = 0; i < 3; i++) send(8'(8'h90 + i), 1'b0);
    bus.flush = 1'b1; bus.rx_done = 1'b1; bus.rx_out = 8'hEE;
    step();
    bus.flush = 1'b0; bus.rx_done = 1'b0;
    step();
    check("t6_flush", 32'(bus.count), 32'(0));

    // T6: async reset mid-stream, rx_done held through release
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    bus.rx_done = 1'b1; bus.rx_out = 8'h5A;
    #2;
    rstn = 1'b0;
    #1;
    q.delete(); m_ovf = 0; m_prev = 0;
    check_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    step();
    bus.rx_done = 1'b0;
    step();
    check("rst_release_push", 32'(bus.count), 32'(1));
    check("rst_release_data", 32'(bus.rd_data), 32'h5A);

    // Random traffic; rd_en rate varies by phase to reach both full and empty
    for (int c = 0; c < 3000; c++) begin
      int rd_mod;
      rd_mod = ((c / 500) % 2 == 0) ? 5 : 2;
      if ($urandom_range(0, 2) == 0) bus.rx_done = ~bus.rx_done;
      bus.rx_out   = 8'($urandom);
      bus.length   = 4'($urandom_range(0, 15));
      bus.rx_error = ($urandom_range(0, 7) == 0);
      bus.rd_en    = ($urandom_range(0, rd_mod - 1) == 0);
      bus.flush    = ($urandom_range(0, 150) == 0);
      bus.ovf_clr  = ($urandom_range(0, 30) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
